// File: rtl/rv32_pkg.sv
// Shared RV32I decode constants: opcodes, instruction format, ALU op codes,
// next-PC and writeback source selectors, plus funct3 -> ALU op helpers.
package rv32_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    INSTR_R = 3'd0, INSTR_I = 3'd1, INSTR_S = 3'd2,
    INSTR_B = 3'd3, INSTR_U = 3'd4, INSTR_J = 3'd5
  } instruction_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,  ALU_SUB = 4'd1,  ALU_SLL = 4'd2,  ALU_SLT = 4'd3,
    ALU_SLTU = 4'd4, ALU_XOR = 4'd5,  ALU_SRL = 4'd6,  ALU_SRA = 4'd7,
    ALU_OR = 4'd8,   ALU_AND = 4'd9,  ALU_EQ = 4'd10,  ALU_NE = 4'd11,
    ALU_GE = 4'd12,  ALU_GEU = 4'd13
  } alu_op_t;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JAL    = 2'd2;
  localparam logic [1:0] PC_JALR   = 2'd3;

  localparam logic [2:0] RES_ALU   = 3'd0;
  localparam logic [2:0] RES_IMM   = 3'd1;
  localparam logic [2:0] RES_PCIMM = 3'd2;
  localparam logic [2:0] RES_PC4   = 3'd3;
  localparam logic [2:0] RES_LOAD  = 3'd4;
  localparam logic [2:0] RES_ZERO  = 3'd5;

  // SUB is only reachable from register-register ops; SRA from both forms.
  function automatic alu_op_t arith_op(input logic [2:0] f3, input logic b30,
                                       input logic is_reg);
    case (f3)
      3'b000:  arith_op = (is_reg && b30) ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = b30 ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  endfunction

  function automatic alu_op_t branch_op(input logic [2:0] f3);
    case (f3)
      3'b001:  branch_op = ALU_NE;
      3'b100:  branch_op = ALU_SLT;
      3'b101:  branch_op = ALU_GE;
      3'b110:  branch_op = ALU_SLTU;
      3'b111:  branch_op = ALU_GEU;
      default: branch_op = ALU_EQ;
    endcase
  endfunction

endpackage

// File: rtl/exec_alu.sv
// Pure combinational RV32 ALU; compares return 0/1, unused codes return 0.
module exec_alu
  import rv32_pkg::*;
(
  input  logic [31:0] i_in1,
  input  logic [31:0] i_in2,
  input  logic [3:0]  i_op,
  output logic [31:0] o_result
);

  logic [4:0] w_shamt;
  assign w_shamt = i_in2[4:0];

  always_comb begin
    o_result = '0;
    case (i_op)
      ALU_ADD:  o_result = i_in1 + i_in2;
      ALU_SUB:  o_result = i_in1 - i_in2;
      ALU_SLL:  o_result = i_in1 << w_shamt;
      ALU_SLT:  o_result = {31'b0, $signed(i_in1) < $signed(i_in2)};
      ALU_SLTU: o_result = {31'b0, i_in1 < i_in2};
      ALU_XOR:  o_result = i_in1 ^ i_in2;
      ALU_SRL:  o_result = i_in1 >> w_shamt;
      ALU_SRA:  o_result = $signed(i_in1) >>> w_shamt;
      ALU_OR:   o_result = i_in1 | i_in2;
      ALU_AND:  o_result = i_in1 & i_in2;
      ALU_EQ:   o_result = {31'b0, i_in1 == i_in2};
      ALU_NE:   o_result = {31'b0, i_in1 != i_in2};
      ALU_GE:   o_result = {31'b0, $signed(i_in1) >= $signed(i_in2)};
      ALU_GEU:  o_result = {31'b0, i_in1 >= i_in2};
      default:  o_result = '0;
    endcase
  end

endmodule

// File: rtl/decode_exec_unit.sv
// RV32I instruction register + decoder + immediate extender + ALU.
// Optional DECODE_ILLEGAL_DETECT_EN adds the illegal_instr output.
module decode_exec_unit
  import rv32_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_load,
  input  logic [31:0]     instr_in,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [31:0]     instr,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  output logic [4:0]      rd_addr,
  output logic [2:0]      funct3,
  output logic [2:0]      instruction_type,
  output logic [1:0]      pc_src,
  output logic [2:0]      result_src,
  output logic [3:0]      alu_control,
  output logic            alu_src,
  output logic [XLEN-1:0] imm_ext,
  output logic [XLEN-1:0] alu_result,
  output logic            reg_wen,
  output logic            mem_wen,
  output logic [XLEN-1:0] mem_addr
`ifdef DECODE_ILLEGAL_DETECT_EN
  ,
  output logic            illegal_instr
`endif
);

  logic [31:0]  r_instr;
  logic [6:0]   w_opcode;
  instruction_t w_type;
  alu_op_t      w_alu_op;
  logic [1:0]   w_pc_src;
  logic [2:0]   w_res_src;
  logic         w_alu_src, w_reg_wen, w_mem_wen;
  logic [31:0]  w_imm;
  logic [31:0]  w_in2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_instr <= RESET_INSTR;
    else if (instr_load) r_instr <= instr_in;
  end

  assign w_opcode = r_instr[6:0];
  assign instr    = r_instr;
  assign rs1_addr = r_instr[19:15];
  assign rs2_addr = r_instr[24:20];
  assign rd_addr  = r_instr[11:7];
  assign funct3   = r_instr[14:12];

  always_comb begin
    w_type    = INSTR_I;
    w_pc_src  = PC_PLUS4;
    w_res_src = RES_ALU;
    w_alu_op  = ALU_ADD;
    w_alu_src = 1'b1;
    w_reg_wen = 1'b0;
    w_mem_wen = 1'b0;
    case (w_opcode)
      OPC_LUI:   begin w_type = INSTR_U; w_res_src = RES_IMM;   w_reg_wen = 1'b1; end
      OPC_AUIPC: begin w_type = INSTR_U; w_res_src = RES_PCIMM; w_reg_wen = 1'b1; end
      OPC_JAL: begin
        w_type = INSTR_J; w_pc_src = PC_JAL; w_res_src = RES_PC4; w_reg_wen = 1'b1;
      end
      OPC_JALR: begin w_pc_src = PC_JALR; w_res_src = RES_PC4; w_reg_wen = 1'b1; end
      OPC_BRANCH: begin
        w_type    = INSTR_B;
        w_alu_src = 1'b0;
        w_alu_op  = branch_op(funct3);
        // funct3 010/011 are not branches: never redirect the PC
        w_pc_src  = (funct3[2:1] == 2'b01) ? PC_PLUS4 : PC_BRANCH;
      end
      OPC_LOAD:  begin w_res_src = RES_LOAD; w_reg_wen = 1'b1; end
      OPC_STORE: begin w_type = INSTR_S; w_mem_wen = 1'b1; end
      OPC_OPIMM: begin w_reg_wen = 1'b1; w_alu_op = arith_op(funct3, r_instr[30], 1'b0); end
      OPC_OP: begin
        w_type    = INSTR_R;
        w_alu_src = 1'b0;
        w_reg_wen = 1'b1;
        w_alu_op  = arith_op(funct3, r_instr[30], 1'b1);
      end
      default:   w_res_src = RES_ZERO;
    endcase
  end

  always_comb begin
    w_imm = '0;
    case (w_type)
      INSTR_I: w_imm = {{20{r_instr[31]}}, r_instr[31:20]};
      INSTR_S: w_imm = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
      INSTR_B: w_imm = {{19{r_instr[31]}}, r_instr[31], r_instr[7], r_instr[30:25],
                        r_instr[11:8], 1'b0};
      INSTR_U: w_imm = {r_instr[31:12], 12'b0};
      INSTR_J: w_imm = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12], r_instr[20],
                        r_instr[30:21], 1'b0};
      default: w_imm = '0;
    endcase
  end

  assign w_in2 = w_alu_src ? w_imm : rs2;

  exec_alu u_alu (
    .i_in1    (rs1),
    .i_in2    (w_in2),
    .i_op     (w_alu_op),
    .o_result (alu_result)
  );

  assign instruction_type = w_type;
  assign pc_src           = w_pc_src;
  assign result_src       = w_res_src;
  assign alu_control      = w_alu_op;
  assign alu_src          = w_alu_src;
  assign imm_ext          = w_imm;
  assign reg_wen          = w_reg_wen;
  assign mem_wen          = w_mem_wen;
  assign mem_addr         = rs1 + w_imm;

`ifdef DECODE_ILLEGAL_DETECT_EN
  logic w_known;
  assign w_known = w_opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                                    OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP};
  // shift-immediates (funct3 x01) only allow funct7 0000000 / 0100000
  assign illegal_instr = !w_known || (r_instr[1:0] != 2'b11)
                      || (w_opcode == OPC_BRANCH && funct3[2:1] == 2'b01)
                      || (w_opcode == OPC_OPIMM && funct3[1:0] == 2'b01
                          && r_instr[31:25] != 7'b0000000 && r_instr[31:25] != 7'b0100000);
`endif

endmodule

// File: tb/tb_decode_exec_unit.sv
// Directed + randomized check of decode_exec_unit against a behavioural RV32I model.
module tb_decode_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_load;
  logic [31:0] instr_in, rs1, rs2;
  logic [31:0] instr, imm_ext, alu_result, mem_addr;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [2:0]  funct3, instruction_type, result_src;
  logic [1:0]  pc_src;
  logic [3:0]  alu_control;
  logic        alu_src, reg_wen, mem_wen;
`ifdef DECODE_ILLEGAL_DETECT_EN
  logic        illegal_instr;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_exec_unit dut (
    .clk(clk), .rst(rst), .instr_load(instr_load), .instr_in(instr_in),
    .rs1(rs1), .rs2(rs2), .instr(instr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd_addr(rd_addr), .funct3(funct3), .instruction_type(instruction_type),
    .pc_src(pc_src), .result_src(result_src), .alu_control(alu_control),
    .alu_src(alu_src), .imm_ext(imm_ext), .alu_result(alu_result),
    .reg_wen(reg_wen), .mem_wen(mem_wen), .mem_addr(mem_addr)
`ifdef DECODE_ILLEGAL_DETECT_EN
    , .illegal_instr(illegal_instr)
`endif
  );

  typedef struct {
    int          typ, pcs, rsrc, wen, mwen, asrc, actl; // -1 = not defined for this opcode
    logic [31:0] imm;
    logic [31:0] res;
    bit          res_valid;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Behavioural reference: decode the word straight from the ISA rules.
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [31:0] s, iI, iS, iB, iU, iJ, op2;
    int f3;
    bit alt;
    s   = w[31] ? 32'hFFFF_FFFF : 32'h0;
    iI  = (s << 12) | (w >> 20);
    iS  = (s << 12) | (((w >> 25) & 32'h7F) << 5) | ((w >> 7) & 32'h1F);
    iB  = (s << 12) | (((w >> 7) & 1) << 11) | (((w >> 25) & 32'h3F) << 5) | (((w >> 8) & 32'hF) << 1);
    iU  = w & 32'hFFFF_F000;
    iJ  = (s << 20) | (((w >> 12) & 32'hFF) << 12) | (((w >> 20) & 1) << 11) | (((w >> 21) & 32'h3FF) << 1);
    f3  = int'(w[14:12]);
    alt = w[30];
    e = '{typ: 1, pcs: 0, rsrc: 0, wen: 0, mwen: 0, asrc: -1, actl: -1,
          imm: iI, res: 32'h0, res_valid: 0};
    case (w[6:0])
      7'b0110111: begin e.typ = 4; e.imm = iU; e.rsrc = 1; e.wen = 1; end
      7'b0010111: begin e.typ = 4; e.imm = iU; e.rsrc = 2; e.wen = 1; end
      7'b1101111: begin e.typ = 5; e.imm = iJ; e.pcs = 2; e.rsrc = 3; e.wen = 1; end
      7'b1100111: begin
        e.pcs = 3; e.rsrc = 3; e.wen = 1; e.asrc = 1; e.actl = 0;
        e.res = a + iI; e.res_valid = 1;
      end
      7'b1100011: begin
        e.typ = 3; e.imm = iB; e.asrc = 0; e.rsrc = -1; e.res_valid = 1;
        e.pcs = (f3 == 2 || f3 == 3) ? 0 : 1;
        case (f3)
          1: begin e.actl = 11; e.res = 32'(a != b); end
          4: begin e.actl = 3;  e.res = 32'($signed(a) <  $signed(b)); end
          5: begin e.actl = 12; e.res = 32'($signed(a) >= $signed(b)); end
          6: begin e.actl = 4;  e.res = 32'(a < b); end
          7: begin e.actl = 13; e.res = 32'(a >= b); end
          default: begin e.actl = 10; e.res = 32'(a == b); end
        endcase
      end
      7'b0000011: begin e.rsrc = 4; e.asrc = 1; e.actl = 0; e.wen = 1; e.res = a + iI; e.res_valid = 1; end
      7'b0100011: begin
        e.typ = 2; e.imm = iS; e.rsrc = -1; e.asrc = 1; e.actl = 0; e.mwen = 1;
        e.res = a + iS; e.res_valid = 1;
      end
      7'b0010011, 7'b0110011: begin
        bit r;
        r = (w[6:0] == 7'b0110011);
        e.wen = 1; e.res_valid = 1;
        if (r) begin e.typ = 0; e.imm = 0; e.asrc = 0; op2 = b; end
        else   begin e.asrc = 1; op2 = iI; end
        case (f3)
          0: if (r && alt) begin e.actl = 1; e.res = a - op2; end
             else          begin e.actl = 0; e.res = a + op2; end
          1: begin e.actl = 2; e.res = a << op2[4:0]; end
          2: begin e.actl = 3; e.res = 32'($signed(a) < $signed(op2)); end
          3: begin e.actl = 4; e.res = 32'(a < op2); end
          4: begin e.actl = 5; e.res = a ^ op2; end
          5: if (alt) begin e.actl = 7; e.res = 32'($signed(a) >>> op2[4:0]); end
             else     begin e.actl = 6; e.res = a >> op2[4:0]; end
          6: begin e.actl = 8; e.res = a | op2; end
          default: begin e.actl = 9; e.res = a & op2; end
        endcase
      end
      default: begin e.rsrc = 5; e.actl = 0; end
    endcase
    return e;
  endfunction

  task automatic load(input logic [31:0] w);
    @(negedge clk);
    instr_in   = w;
    instr_load = 1'b1;
    @(posedge clk);
    #1;
    instr_load = 1'b0;
    instr_in   = $urandom;
  endtask

  task automatic check_all(input string tag, input logic [31:0] w);
    exp_t e;
    e = model(w, rs1, rs2);
    check({tag, ".instr"},  instr, w);
    check({tag, ".rs1a"},   32'(rs1_addr), 32'(w[19:15]));
    check({tag, ".rs2a"},   32'(rs2_addr), 32'(w[24:20]));
    check({tag, ".rda"},    32'(rd_addr), 32'(w[11:7]));
    check({tag, ".f3"},     32'(funct3), 32'(w[14:12]));
    check({tag, ".type"},   32'(instruction_type), 32'(e.typ));
    check({tag, ".pcsrc"},  32'(pc_src), 32'(e.pcs));
    check({tag, ".wen"},    32'(reg_wen), 32'(e.wen));
    check({tag, ".mwen"},   32'(mem_wen), 32'(e.mwen));
    check({tag, ".imm"},    imm_ext, e.imm);
    check({tag, ".maddr"},  mem_addr, rs1 + e.imm);
    if (e.rsrc >= 0) check({tag, ".rsrc"}, 32'(result_src), 32'(e.rsrc));
    if (e.asrc >= 0) check({tag, ".asrc"}, 32'(alu_src), 32'(e.asrc));
    if (e.actl >= 0) check({tag, ".actl"}, 32'(alu_control), 32'(e.actl));
    if (e.res_valid) check({tag, ".res"},  alu_result, e.res);
  endtask

  localparam logic [6:0] OPCS [9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                                      7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
                                      7'b0110011};

  initial begin
    logic [31:0] w;
    rst = 1'b1; instr_load = 1'b0; instr_in = 32'h0; rs1 = 32'h0; rs2 = 32'h0;
    #2;
    check("rst.instr",  instr, 32'h0000_0013);
    check("rst.imm",    imm_ext, 32'h0);
    check("rst.asrc",   32'(alu_src), 32'd1);
    check("rst.wen",    32'(reg_wen), 32'd1);
    check("rst.rsrc",   32'(result_src), 32'd0);
    check("rst.actl",   32'(alu_control), 32'd0);
    // reset dominates a simultaneous load
    instr_in = 32'h402081B3; instr_load = 1'b1;
    @(posedge clk); #1;
    check("rst.prio", instr, 32'h0000_0013);
    @(negedge clk);
    rst = 1'b0; instr_load = 1'b0;

    load(32'h00500093); rs1 = 0; #1;
    check("addi.imm",  imm_ext, 32'd5);
    check("addi.actl", 32'(alu_control), 32'd0);
    check("addi.res",  alu_result, 32'd5);
    check("addi.rsrc", 32'(result_src), 32'd0);

    // asynchronous reset between clock edges
    @(posedge clk); #3;
    rst = 1'b1; #1;
    check("rst.async", instr, 32'h0000_0013);
    @(negedge clk); rst = 1'b0;

    load(32'h402081B3); rs1 = 3; rs2 = 5; #1;
    check("sub.actl", 32'(alu_control), 32'd1);
    check("sub.res",  alu_result, 32'hFFFF_FFFE);
    check("sub.type", 32'(instruction_type), 32'd0);

    load(32'h4040D093); rs1 = 32'h8000_0000; #1;
    check("srai.imm",  imm_ext, 32'h404);
    check("srai.actl", 32'(alu_control), 32'd7);
    check("srai.res",  alu_result, 32'hF800_0000);

    load(32'hFE208CE3); rs1 = 7; rs2 = 7; #1;
    check("beq.imm",   imm_ext, 32'hFFFF_FFF8);
    check("beq.res",   alu_result, 32'd1);
    check("beq.pcsrc", 32'(pc_src), 32'd1);
    check("beq.wen",   32'(reg_wen), 32'd0);
    rs2 = 8; #1;
    check("beq.res2",  alu_result, 32'd0);

    load(32'h123450B7); #1;
    check("lui.imm",  imm_ext, 32'h1234_5000);
    check("lui.rsrc", 32'(result_src), 32'd1);
    @(negedge clk); instr_in = 32'hDEADBEEF; instr_load = 1'b0;
    @(posedge clk); #1;
    check("lui.hold", instr, 32'h1234_50B7);

    for (int n = 0; n < 400; n++) begin
      w = $urandom;
      if (n % 10 != 9) w[6:0] = OPCS[$urandom_range(0, 8)];
      load(w);
      rs1 = $urandom;
      case ($urandom_range(0, 3))
        0:       rs2 = rs1;
        1:       rs2 = rs1 ^ 32'h8000_0000;
        default: rs2 = $urandom;
      endcase
      #1;
      check_all($sformatf("rnd%0d", n), w);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_exec_unit.md
Name: decode_exec_unit

Overview:
- RV32I decode-and-execute slice: instruction register, main decoder (control), immediate extender and ALU in one block.
- Sits between instruction fetch/memory and the register file / PC selector of the multi-cycle core.
- Captures the fetched word on `instr_load`, then combinationally produces control, immediate and ALU result from the held instruction plus operand values supplied by the register file.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RESET_INSTR, 32'h0000_0013, instruction-register reset value (`addi x0,x0,0`).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- instr_load  in  1  capture `instr_in` this edge (fetch complete)
- instr_in  in  32  fetched instruction word
- rs1  in  32  register-file read data 1
- rs2  in  32  register-file read data 2
- instr  out  32  held instruction
- rs1_addr / rs2_addr / rd_addr  out  5 each  `instr[19:15]` / `instr[24:20]` / `instr[11:7]`
- funct3  out  3  `instr[14:12]`
- instruction_type  out  3  R=0, I=1, S=2, B=3, U=4, J=5
- pc_src  out  2  0 = pc+4; 1 = branch, take pc+imm if `alu_result[0]`; 2 = JAL pc+imm; 3 = JALR (rs1+imm)&~1
- result_src  out  3  0 = ALU, 1 = imm (LUI), 2 = pc+imm (AUIPC), 3 = pc+4 (JAL/JALR), 4 = load data, 5 = zero
- alu_control  out  4  ALU operation code
- alu_src  out  1  ALU operand 2 is imm_ext (1) or rs2 (0)
- imm_ext  out  32  sign-extended immediate
- alu_result  out  32  ALU output
- reg_wen  out  1  register writeback enable
- mem_wen  out  1  store enable
- mem_addr  out  32  rs1 + imm_ext

Behaviour:
- Instruction register:
  - rst=1 asynchronously forces instr=RESET_INSTR; rst has priority over instr_load.
  - Otherwise instr<=instr_in on a clk rising edge with instr_load=1, else it holds.
  - All other outputs are combinational from instr/rs1/rs2.
  - In reset, outputs therefore decode the NOP: ADD, imm_ext=0, alu_src=1, reg_wen=1, result_src=0.
- Opcodes and decode:
  - LUI 0110111: U-type, result_src 1, reg_wen 1.
  - AUIPC 0010111: U-type, result_src 2, reg_wen 1.
  - JAL 1101111: J-type, pc_src 2, result_src 3, reg_wen 1.
  - JALR 1100111: I-type, pc_src 3, result_src 3, reg_wen 1, alu_src 1, ADD.
  - BRANCH 1100011: B-type, pc_src 1, alu_src 0, reg_wen 0.
  - LOAD 0000011: I-type, result_src 4, alu_src 1, ADD, reg_wen 1.
  - STORE 0100011: S-type, alu_src 1, ADD, reg_wen 0, mem_wen 1.
  - OP_IMM 0010011: I-type, alu_src 1, result_src 0, reg_wen 1.
  - OP 0110011: R-type, alu_src 0, result_src 0, reg_wen 1.
  - Unlisted opcode: type I, pc_src 0, result_src 5, reg_wen 0, mem_wen 0, ADD.
  - pc_src is 0 and mem_wen is 0 for every opcode where not stated above.
- ALU codes: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, EQ 10, NE 11, GE 12, GEU 13.
  - Compare ops return 32'd1 or 32'd0.
  - Codes 14–15 return 0.
  - Shift amount is `in2[4:0]`.
- funct3 → ALU op for OP/OP_IMM: 000 ADD (SUB only for OP with `instr[30]`=1; OP_IMM ignores bit 30), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA by `instr[30]`, 110 OR, 111 AND.
- Branch funct3 → ALU op: 000 EQ, 001 NE, 100 SLT, 101 GE, 110 SLTU, 111 GEU; 010/011 → EQ with pc_src forced to 0.
- Immediates, all sign-extended from `instr[31]`:
  - I: `instr[31:20]`.
  - S: {`[31:25]`,`[11:7]`}.
  - B: {`[31]`,`[7]`,`[30:25]`,`[11:8]`,0}.
  - U: {`[31:12]`,12'b0}.
  - J: {`[31]`,`[19:12]`,`[20]`,`[30:21]`,0}.
  - R-type: 0.
- All adds wrap modulo 2^32; there are no overflow flags.

Optional Feature:
- Macro DECODE_ILLEGAL_DETECT_EN: adds output `illegal_instr` (1 bit), high for an unlisted opcode, `instr[1:0]`≠2'b11, branch funct3 010/011, or shift-immediate with `instr[31:25]` not 0000000/0100000.
- Without the macro the port is absent and decoding is unchanged.

Decomposition:
- Shared package `rv32_pkg`: opcode localparams, `instruction_t` enum, `alu_op_t` enum, pc_src/result_src constants.
- One natural sub-module, `exec_alu` (pure combinational ALU); decoder and immediate logic stay in the top.

Test Plan:
- Reset: assert rst mid-cycle → instr=0x00000013 immediately, imm_ext=0, alu_src=1, reg_wen=1.
- Load 0x00500093 (`addi x1,x0,5`), rs1=0 → imm_ext=5, alu_control=0, alu_result=5, result_src=0.
- Load 0x402081B3 (`sub`), rs1=3, rs2=5 → alu_control=1, alu_result=0xFFFFFFFE, instruction_type=R.
- Load 0x4040D093 (`srai x1,x1,4`), rs1=0x80000000 → imm_ext=0x404, alu_control=7, alu_result=0xF8000000.
- Load 0xFE208CE3 (`beq x1,x2,-8`), rs1=rs2=7 → imm_ext=0xFFFFFFF8, alu_result=1, pc_src=1, reg_wen=0; then rs2=8 → alu_result=0.
- Load 0x123450B7 (`lui`) → imm_ext=0x12345000, result_src=1; hold instr_load=0 with new instr_in → instr unchanged.
